// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: an 8-byte register window on the core data bus
// feeds a small byte FIFO that is drained LSB-first onto the serial line.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        tx,
    output logic        busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TIMER_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state, state_nx;
    logic [TW-1:0]   timer, timer_nx;
    logic [2:0]      bit_idx, bit_idx_nx;
    logic [7:0]      shift, shift_nx;
    logic            tx_nx;
    logic            timer_wrap;

    logic [7:0]      fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            ovf;
    logic            full, empty;
    logic            sel_txdata, sel_status;
    logic            push, pop, drop, ovf_clr;
    logic            unused_bits;

    // Decode on word addresses only; byte offset and upper data bits are don't-care.
    assign sel_txdata  = (mem_addr[31:2] == BASE_ADDR[31:2]);
    assign sel_status  = (mem_addr[31:2] == (BASE_ADDR[31:2] + 30'd1));
    assign unused_bits = &{1'b0, mem_wdata[31:8], mem_addr[1:0]};

    assign full    = (count == COUNT_FULL);
    assign empty   = (count == '0);
    assign pop     = (state == IDLE) && !empty;
    assign push    = mem_we && sel_txdata && (!full || pop);
    assign drop    = mem_we && sel_txdata && full && !pop;
    assign ovf_clr = mem_we && sel_status && mem_wdata[3];

    assign busy      = (state != IDLE) || !empty;
    assign mem_rdata = sel_status ? {28'b0, ovf, empty, full, busy} : 32'b0;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_wdata[7:0];
        end
    end

    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands then.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_nx;
            timer   <= timer_nx;
            bit_idx <= bit_idx_nx;
            shift   <= shift_nx;
            tx      <= tx_nx;
        end
    end

    assign timer_wrap = (timer == TIMER_LAST);

    // tx is registered from the next-state values so the line changes on the same edge as the FSM.
    always_comb begin
        state_nx   = state;
        timer_nx   = timer;
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        tx_nx      = 1'b1;

        case (state)
            IDLE: begin
                if (!empty) begin
                    shift_nx = fifo_mem[rd_ptr];
                    timer_nx = '0;
                    state_nx = START;
                end
            end
            START: begin
                if (timer_wrap) begin
                    timer_nx   = '0;
                    bit_idx_nx = '0;
                    state_nx   = DATA;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            DATA: begin
                if (timer_wrap) begin
                    timer_nx = '0;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end else begin
                        shift_nx   = shift >> 1;
                        bit_idx_nx = bit_idx + 1'b1;
                    end
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            STOP: begin
                if (timer_wrap) begin
                    timer_nx = '0;
                    state_nx = IDLE;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        case (state_nx)
            START:   tx_nx = 1'b0;
            DATA:    tx_nx = shift_nx[0];
            default: tx_nx = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomised and directed bench for mmio_uart_tx, compared each cycle against a
// frame-position reference model built on a byte queue.
module tb_mmio_uart_tx;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_we = 1'b0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        tx;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: pending bytes, position inside the current frame (-1 = idle line).
    logic [7:0] mq[$];
    int         fpos = -1;
    logic [7:0] cur = 8'h0;
    logic       movf = 1'b0;

    always #5 clk = ~clk;

    mmio_uart_tx #(
        .BASE_ADDR   (BASE),
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .tx       (tx),
        .busy     (busy)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic model_busy();
        return (fpos >= 0) || (mq.size() > 0);
    endfunction

    function automatic logic model_tx();
        int k;
        if (fpos < 0) return 1'b1;
        k = fpos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return cur[k-1];
        return 1'b1;
    endfunction

    function automatic logic [31:0] model_rdata(input logic [31:0] a);
        if (a[31:2] == BASE[31:2] + 30'd1)
            return {28'b0, movf, mq.size() == 0, mq.size() == DEPTH, model_busy()};
        return 32'h0;
    endfunction

    task automatic model_edge(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        logic popn;
        logic was_full;
        if (!r) begin
            mq.delete();
            fpos = -1;
            movf = 1'b0;
        end else begin
            popn     = (fpos < 0) && (mq.size() > 0);
            was_full = (mq.size() == DEPTH);
            if (fpos >= 0) begin
                fpos++;
                if (fpos == 10 * CPB) fpos = -1;
            end
            if (popn) begin
                cur  = mq.pop_front();
                fpos = 0;
            end
            if (we && a[31:2] == BASE[31:2]) begin
                if (!was_full || popn) mq.push_back(d[7:0]);
                else movf = 1'b1;
            end
            if (we && a[31:2] == BASE[31:2] + 30'd1 && d[3]) movf = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic r, input logic we, input logic [31:0] a, input logic [31:0] d);
        rst       = r;
        mem_we    = we;
        mem_addr  = a;
        mem_wdata = d;
        @(negedge clk);
        checkOutput("rdata", mem_rdata, model_rdata(a));
        @(posedge clk);
        model_edge(r, we, a, d);
        #1;
        checkOutput("tx", {31'b0, tx}, {31'b0, model_tx()});
        checkOutput("busy", {31'b0, busy}, {31'b0, model_busy()});
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, BASE + 32'h4, 32'h0);
    endtask

    task automatic statusIs(input string tag, input logic [31:0] exp);
        mem_we   = 1'b0;
        mem_addr = BASE + 32'h4;
        #1;
        checkOutput(tag, mem_rdata, exp);
    endtask

    initial begin
        int n;
        logic [31:0] a;
        logic [31:0] d;

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, BASE + 32'h4, 32'h0);
        statusIs("reset_status", 32'h4);
        checkOutput("reset_tx", {31'b0, tx}, 32'h1);

        applyStimulus(1'b1, 1'b1, BASE, 32'hA5);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            applyStimulus(1'b1, 1'b0, BASE + 32'h4, 32'h0);
            n++;
        end
        checkOutput("a5_frame_cycles", n, 32'd41);
        idleCycles(3);

        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 1'b1, BASE, 32'h11 * i);
        statusIs("five_full_status", 32'h3);
        idleCycles(5 * 41 + 5);

        for (int i = 1; i <= 6; i++) applyStimulus(1'b1, 1'b1, BASE, 32'h20 + i);
        statusIs("six_ovf_status", 32'hB);
        applyStimulus(1'b1, 1'b1, BASE + 32'h4, 32'h8);
        statusIs("ovf_cleared", 32'h3);
        idleCycles(5 * 41 + 5);

        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b1, BASE, 32'h3C + i);
        idleCycles(13);
        applyStimulus(1'b0, 1'b0, BASE + 32'h4, 32'h0);
        checkOutput("midframe_rst_tx", {31'b0, tx}, 32'h1);
        statusIs("midframe_rst_status", 32'h4);
        idleCycles(50);

        applyStimulus(1'b1, 1'b1, BASE + 32'h8, 32'h77);
        applyStimulus(1'b1, 1'b0, 32'h0000_2000, 32'h0);
        mem_addr = 32'h0000_2000;
        #1;
        checkOutput("outside_rdata", mem_rdata, 32'h0);
        statusIs("no_push_status", 32'h4);

        for (int i = 0; i < 800; i++) begin
            case ($urandom_range(0, 4))
                0, 1:    a = BASE;
                2:       a = BASE + 32'h4 + 32'($urandom_range(0, 3));
                3:       a = BASE + 32'h8;
                default: a = $urandom;
            endcase
            d = $urandom;
            applyStimulus(($urandom_range(0, 199) != 0), ($urandom_range(0, 9) < 3), a, d);
        end
        idleCycles(5 * 41 + 5);
        statusIs("final_status", {28'b0, movf, 1'b1, 1'b0, 1'b0});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
